// File: rtl/spi_master_pkg.sv
// Shared types and constants for the mode-0 SPI master frame sequencer.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SCLK_HI,
    SCLK_LO,
    TRAIL
  } spi_state_e;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_master_ctrl_bit_cnt.sv
// Bit-position counter for the SPI frame; held cleared while enable_i is low,
// advances on step_i, and flags the final bit position with last_o.
module spi_bit_cnt #(
  parameter int CNT_W = 3
) (
  input  logic clk_c,
  input  logic reset_r,
  input  logic enable_i,
  input  logic step_i,
  output logic last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (enable_i) begin
      cnt_d = step_i ? cnt_q + CNT_W'(1) : cnt_q;
    end
  end

  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = &cnt_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master frame sequencer: FSM, sclk divider, tx/rx shift registers.
// Optional back-to-back framing with cs_n held low: `define SPI_MASTER_BURST_EN.
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  localparam int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk_c,
  input  logic              reset_r,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_n_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  spi_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              done_q, done_d;
  logic              tick;
  logic              accept;
  logic              bit_en;
  logic              bit_step;
  logic              bit_last;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

`ifdef SPI_MASTER_BURST_EN
  assign ready_o = (state_q == IDLE) || ((state_q == TRAIL) && tick);
`else
  assign ready_o = (state_q == IDLE);
`endif

  assign accept = start_i && ready_o;
  assign bit_en = (state_q == SCLK_HI) || (state_q == SCLK_LO);

  spi_bit_cnt #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk_c    (clk_c),
    .reset_r  (reset_r),
    .enable_i (bit_en),
    .step_i   (bit_step),
    .last_o   (bit_last)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = (state_q == IDLE || tick) ? '0 : div_q + DIV_W'(1);
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    done_d    = 1'b0;
    bit_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (accept) begin
          tx_d    = tx_data_i;
          cs_n_d  = 1'b0;
          mosi_d  = tx_data_i[DATA_W-1];
          state_d = LEAD;
        end
      end
      LEAD, SCLK_LO: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[DATA_W-2:0], miso_i};
          state_d = SCLK_HI;
        end
      end
      SCLK_HI: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_last) begin
            state_d = TRAIL;
          end else begin
            tx_d     = {tx_q[DATA_W-2:0], 1'b0};
            mosi_d   = tx_q[DATA_W-2];
            bit_step = 1'b1;
            state_d  = SCLK_LO;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          cs_n_d    = 1'b1;
          rx_data_d = rx_q;
          done_d    = 1'b1;
          state_d   = IDLE;
`ifdef SPI_MASTER_BURST_EN
          // Chained frame: chip select never releases between words.
          if (accept) begin
            cs_n_d  = 1'b0;
            tx_d    = tx_data_i;
            mosi_d  = tx_data_i[DATA_W-1];
            state_d = LEAD;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r) begin
      state_q   <= IDLE;
      div_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: loopback and slave-model frames, ignored
// starts, mid-frame reset, chained frames (SPI_MASTER_BURST_EN aware) and CLK_DIV=1.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

  localparam int DATA_W = 8;
  localparam int LAT    = 68;
  localparam int LAT1   = 17;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         acc;
    bit         chkMosi;
  } exp_t;

  logic       clk_c = 1'b0;
  logic       reset_r = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] tx_data_i = '0;
  logic       ready_o, busy_o, done_o, sclk_o, mosi_o, cs_n_o;
  logic       miso_i;
  logic [7:0] rx_data_o;

  logic       start1 = 1'b0;
  logic [7:0] tx1 = '0;
  logic       ready1, busy1, done1, sclk1, mosi1, cs1;
  logic [7:0] rx1;

  exp_t       sb[$];
  int         vecCount = 0;
  int         missCount = 0;
  int         cycle = 0;
  int         riseCnt = 0;
  int         doneCount = 0;
  int         csHighCnt = 0;
  bit         csWatch = 0;
  bit         loopMode = 1;
  logic [7:0] slvWord = '0;
  logic [7:0] mosiCap = '0;
  logic       prevSclk = 1'b0;

  spi_master_ctrl #(.DATA_W(DATA_W), .CLK_DIV(4)) dut (
    .clk_c(clk_c), .reset_r(reset_r), .start_i(start_i), .tx_data_i(tx_data_i),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .rx_data_o(rx_data_o),
    .sclk_o(sclk_o), .mosi_o(mosi_o), .miso_i(miso_i), .cs_n_o(cs_n_o)
  );

  spi_master_ctrl #(.DATA_W(DATA_W), .CLK_DIV(1)) dut1 (
    .clk_c(clk_c), .reset_r(reset_r), .start_i(start1), .tx_data_i(tx1),
    .ready_o(ready1), .busy_o(busy1), .done_o(done1), .rx_data_o(rx1),
    .sclk_o(sclk1), .mosi_o(mosi1), .miso_i(mosi1), .cs_n_o(cs1)
  );

  // System clock and a free-running cycle index used for latency checks.
  always #5 clk_c = ~clk_c;

  always @(posedge clk_c) cycle <= cycle + 1;

  // Slave: loopback, or present slvWord MSB first, advancing after each sclk rise.
  always_comb begin
    if (loopMode) miso_i = mosi_o;
    else if (riseCnt < 8) miso_i = slvWord[3'(7 - riseCnt)];
    else miso_i = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: count sclk rises, capture mosi bits, score each done_o pulse.
  always @(negedge clk_c) begin
    exp_t e;
    if (reset_r) begin
      riseCnt  = 0;
      prevSclk = 1'b0;
    end else begin
      if (sclk_o && !prevSclk) begin
        riseCnt++;
        mosiCap = {mosiCap[6:0], mosi_o};
      end
      prevSclk = sclk_o;
      if (csWatch && cs_n_o) csHighCnt++;
      if (done_o) begin
        doneCount++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_done_queue", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          checkOutput("rx_data", rx_data_o, e.rx);
          checkOutput("latency", cycle - e.acc, LAT);
          checkOutput("sclk_rises", riseCnt, 8);
          if (e.chkMosi) checkOutput("mosi_bits", mosiCap, e.tx);
        end
        riseCnt = 0;
      end
    end
  end

  // Drive one single-cycle start and log the expected frame result.
  task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] rxExp, input bit chk);
    int guard = 0;
    while (!ready_o && guard < 300) begin
      @(negedge clk_c);
      guard++;
    end
    checkOutput("ready_before_start", ready_o, 1);
    start_i   = 1'b1;
    tx_data_i = tx;
    sb.push_back('{tx, rxExp, cycle + 1, chk});
    @(negedge clk_c);
    start_i   = 1'b0;
    tx_data_i = 8'h00;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge clk_c);
      guard++;
    end
    @(negedge clk_c);
    checkOutput("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int t0;
    int guard;

    repeat (3) @(negedge clk_c);
    checkOutput("rst_ready", ready_o, 1);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_cs_n", cs_n_o, 1);
    checkOutput("rst_sclk", sclk_o, 0);
    checkOutput("rst_mosi", mosi_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_rx", rx_data_o, 0);
    reset_r = 1'b0;
    @(negedge clk_c);

    // Loopback frame, then slave-model frame with all-ones transmit.
    applyStimulus(8'hA5, 8'hA5, 1);
    waitDrain();
    loopMode = 0;
    slvWord  = 8'h3C;
    applyStimulus(8'hFF, 8'h3C, 1);
    waitDrain();
    loopMode = 1;

    // Start pulse mid-frame must be ignored.
    d0 = doneCount;
    applyStimulus(8'h96, 8'h96, 1);
    repeat (26) @(negedge clk_c);
    checkOutput("busy_mid", busy_o, 1);
    checkOutput("ready_mid", ready_o, 0);
    start_i   = 1'b1;
    tx_data_i = 8'h11;
    @(negedge clk_c);
    start_i   = 1'b0;
    tx_data_i = 8'h00;
    waitDrain();
    repeat (80) @(negedge clk_c);
    checkOutput("done_count_ignore", doneCount - d0, 1);

    // Reset around bit 4 aborts the frame immediately.
    d0 = doneCount;
    applyStimulus(8'hC3, 8'hC3, 1);
    repeat (30) @(negedge clk_c);
    reset_r = 1'b1;
    #1;
    checkOutput("abort_cs_n", cs_n_o, 1);
    checkOutput("abort_sclk", sclk_o, 0);
    checkOutput("abort_ready", ready_o, 1);
    checkOutput("abort_busy", busy_o, 0);
    checkOutput("abort_rx", rx_data_o, 0);
    sb.delete();
    repeat (2) @(negedge clk_c);
    reset_r = 1'b0;
    @(negedge clk_c);
    applyStimulus(8'h5A, 8'h5A, 1);
    waitDrain();
    repeat (5) @(negedge clk_c);
    checkOutput("done_count_abort", doneCount - d0, 1);

    // Two frames with start_i held high.
    d0        = doneCount;
    csHighCnt = 0;
    start_i   = 1'b1;
    tx_data_i = 8'h01;
    sb.push_back('{8'h01, 8'h01, cycle + 1, 1'b1});
    @(negedge clk_c);
    tx_data_i = 8'h02;
    csWatch   = 1;
    repeat (67) @(negedge clk_c);
`ifndef SPI_MASTER_BURST_EN
    @(negedge clk_c);
`endif
    sb.push_back('{8'h02, 8'h02, cycle + 1, 1'b1});
    @(negedge clk_c);
    start_i   = 1'b0;
    tx_data_i = 8'h00;
    repeat (40) @(negedge clk_c);
    csWatch = 0;
    waitDrain();
    checkOutput("done_count_pair", doneCount - d0, 2);
`ifdef SPI_MASTER_BURST_EN
    checkOutput("cs_gap_cycles", csHighCnt, 0);
`else
    checkOutput("cs_gap_cycles", csHighCnt, 1);
`endif

    // Fastest divider: loopback frame in 17 cycles.
    start1 = 1'b1;
    tx1    = 8'hA5;
    t0     = cycle + 1;
    @(negedge clk_c);
    start1 = 1'b0;
    tx1    = 8'h00;
    guard  = 0;
    while (!done1 && guard < 100) begin
      @(negedge clk_c);
      guard++;
    end
    checkOutput("div1_latency", cycle - t0, LAT1);
    checkOutput("div1_rx", rx1, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
